// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, ALU SELECT codes, FSM states,
// DATA2 operand selects, and the opcode decoder used in the DECODE state.
package alu_sequencer_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  typedef enum logic [2:0] {
    ALUOP_FWD = 3'b000,
    ALUOP_ADD = 3'b001,
    ALUOP_AND = 3'b010,
    ALUOP_OR  = 3'b011
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    D2_IMM = 2'd0,
    D2_REG = 2'd1,
    D2_NEG = 2'd2
  } data2_sel_e;

  // Only the instruction bits the datapath consumes; src2 is imm[2:0].
  typedef struct packed {
    logic [7:0] opcode;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [7:0] imm;
  } instr_t;

  typedef struct packed {
    logic       legal;
    logic       arith;
    aluop_e     aluop;
    data2_sel_e sel;
  } decode_t;

  function automatic decode_t decode_op(input logic [7:0] opcode);
    decode_t d;
    d.legal = 1'b1;
    d.arith = 1'b0;
    d.aluop = ALUOP_FWD;
    d.sel   = D2_REG;
    case (opcode)
      OP_LOADI: d.sel = D2_IMM;
      OP_MOV:   d.sel = D2_REG;
      OP_ADD: begin
        d.arith = 1'b1;
        d.aluop = ALUOP_ADD;
      end
      OP_SUB: begin
        d.arith = 1'b1;
        d.aluop = ALUOP_ADD;
        d.sel   = D2_NEG;
      end
      OP_AND:   d.aluop = ALUOP_AND;
      OP_OR:    d.aluop = ALUOP_OR;
      default: begin
        d.legal = 1'b0;
        d.sel   = D2_IMM;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_seq_operand_mux.sv
// ALU DATA2 operand select: immediate, register read port 2, or its two's complement.
// Purely combinational so DATA2 follows register-file changes within the cycle.
module alu_seq_operand_mux
  import alu_sequencer_pkg::*;
(
  input  data2_sel_e sel_i,
  input  logic [7:0] imm_i,
  input  logic [7:0] regout2_i,
  output logic [7:0] data2_o
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves data2_o unassigned (latch).
    data2_o = imm_i;
    case (sel_i)
      D2_REG:  data2_o = regout2_i;
      D2_NEG:  data2_o = ~regout2_i + 8'd1;
      default: data2_o = imm_i;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit: accepts one instruction via valid/ready, decodes it,
// drives register-file addresses and ALU controls, waits the ALU settle time, then writes back.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int LOGIC_CYCLES = 1,
  parameter int ARITH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic [7:0]  REGOUT2,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic        WRITEENABLE,
  output logic [2:0]  ALUOP,
  output logic [7:0]  ALU_DATA2,
  output logic        BUSY,
  output logic        ILLEGAL
);

  localparam int MAX_CYCLES = (LOGIC_CYCLES > ARITH_CYCLES) ? LOGIC_CYCLES : ARITH_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOGIC_LOAD = CNT_W'(LOGIC_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARITH_LOAD = CNT_W'(ARITH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  instr_t           instr_q, instr_d;
  logic             illegal_q, illegal_d;
  logic [2:0]       rr1_q, rr1_d;
  logic [2:0]       rr2_q, rr2_d;
  logic [2:0]       wr_q, wr_d;
  aluop_e           aluop_q, aluop_d;
  logic [7:0]       imm_q, imm_d;
  data2_sel_e       sel_q, sel_d;
  decode_t          dec;

  // Register-field padding bits carry no meaning for this datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  assign dec = decode_op(instr_q.opcode);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    rr1_d     = rr1_q;
    rr2_d     = rr2_q;
    wr_d      = wr_q;
    aluop_d   = aluop_q;
    imm_d     = imm_q;
    sel_d     = sel_q;

    case (state_q)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          instr_d.opcode = INSTRUCTION[31:24];
          instr_d.dest   = INSTRUCTION[18:16];
          instr_d.src1   = INSTRUCTION[10:8];
          instr_d.imm    = INSTRUCTION[7:0];
          illegal_d      = 1'b0;
          state_d        = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (dec.legal) begin
          rr1_d   = instr_q.src1;
          rr2_d   = instr_q.imm[2:0];
          wr_d    = instr_q.dest;
          aluop_d = dec.aluop;
          imm_d   = instr_q.imm;
          sel_d   = dec.sel;
          cnt_d   = dec.arith ? ARITH_LOAD : LOGIC_LOAD;
          state_d = ST_EXEC;
        end else begin
          // Park the datapath controls in a harmless state; nothing is written.
          rr1_d     = '0;
          rr2_d     = '0;
          wr_d      = '0;
          aluop_d   = ALUOP_FWD;
          imm_d     = '0;
          sel_d     = D2_IMM;
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WB:   state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      rr1_q     <= '0;
      rr2_q     <= '0;
      wr_q      <= '0;
      aluop_q   <= ALUOP_FWD;
      imm_q     <= '0;
      sel_q     <= D2_IMM;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
      rr1_q     <= rr1_d;
      rr2_q     <= rr2_d;
      wr_q      <= wr_d;
      aluop_q   <= aluop_d;
      imm_q     <= imm_d;
      sel_q     <= sel_d;
    end
  end

  alu_seq_operand_mux u_operand_mux (
    .sel_i     (sel_q),
    .imm_i     (imm_q),
    .regout2_i (REGOUT2),
    .data2_o   (ALU_DATA2)
  );

  assign INSTR_READY = (state_q == ST_IDLE);
  assign BUSY        = (state_q != ST_IDLE);
  assign WRITEENABLE = (state_q == ST_WB);
  assign READREG1    = rr1_q;
  assign READREG2    = rr2_q;
  assign WRITEREG    = wr_q;
  assign ALUOP       = aluop_q;
  assign ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions push expected write-backs,
// a negedge monitor pops and compares on every WRITEENABLE pulse.
module tb_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  REGOUT2;
  logic [2:0]  READREG1, READREG2, WRITEREG, ALUOP;
  logic        WRITEENABLE, BUSY, ILLEGAL;
  logic [7:0]  ALU_DATA2;

  alu_sequencer #(
    .LOGIC_CYCLES (1),
    .ARITH_CYCLES (2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .REGOUT2     (REGOUT2),
    .READREG1    (READREG1),
    .READREG2    (READREG2),
    .WRITEREG    (WRITEREG),
    .WRITEENABLE (WRITEENABLE),
    .ALUOP       (ALUOP),
    .ALU_DATA2   (ALU_DATA2),
    .BUSY        (BUSY),
    .ILLEGAL     (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         wb_cyc;
    logic [2:0] wr;
    logic [2:0] rr1;
    logic [2:0] rr2;
    logic [2:0] aluop;
    logic [7:0] data2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Write-back happens in the cycle after edge k+1+cycles, where k is the accept edge.
  task automatic expect_wr(input int k, input int cycles, input logic [2:0] wr,
                           input logic [2:0] rr1, input logic [2:0] rr2,
                           input logic [2:0] aluop, input logic [7:0] data2);
    exp_t e;
    e.wb_cyc = k + 1 + cycles;
    e.wr     = wr;
    e.rr1    = rr1;
    e.rr2    = rr2;
    e.aluop  = aluop;
    e.data2  = data2;
    exp_q.push_back(e);
  endtask

  // Advance to the first falling edge at which cyc >= t.
  task automatic wait_neg(input int t);
    @(negedge CLK);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic send(input logic [31:0] ins, output int k);
    int n;
    n = 0;
    @(negedge CLK);
    while (INSTR_READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (INSTR_READY !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: INSTR_READY=%b after %0d cycles, required 1", INSTR_READY, n);
    end
    INSTRUCTION = ins;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1;
    k = cyc;
    INSTR_VALID = 1'b0;
    INSTRUCTION = 32'hDEAD_BEEF;
  endtask

  always @(negedge CLK) begin
    if (WRITEENABLE === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: WRITEENABLE=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_cycle",    cyc,       mon_e.wb_cyc);
        check("wb_writereg", WRITEREG,  mon_e.wr);
        check("wb_readreg1", READREG1,  mon_e.rr1);
        check("wb_readreg2", READREG2,  mon_e.rr2);
        check("wb_aluop",    ALUOP,     mon_e.aluop);
        check("wb_data2",    ALU_DATA2, mon_e.data2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    RESET       = 1'b1;
    INSTR_VALID = 1'b0;
    INSTRUCTION = 32'h0;
    REGOUT2     = 8'h00;
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;

    @(negedge CLK);
    check("rst_ready",   INSTR_READY, 1'b1);
    check("rst_busy",    BUSY,        1'b0);
    check("rst_we",      WRITEENABLE, 1'b0);
    check("rst_illegal", ILLEGAL,     1'b0);
    check("rst_aluop",   ALUOP,       3'b000);
    check("rst_data2",   ALU_DATA2,   8'h00);
    check("rst_addrs",   {READREG1, READREG2, WRITEREG}, 9'h000);

    // LOADI r3,0x2A
    REGOUT2 = 8'h77;
    send(32'h0003_002A, k);
    expect_wr(k, 1, 3'd3, 3'd0, 3'd2, 3'b000, 8'h2A);
    wait_neg(k);
    check("loadi_decode_ready", INSTR_READY, 1'b0);
    check("loadi_decode_busy",  BUSY,        1'b1);
    wait_neg(k + 1);
    check("loadi_exec_we",      WRITEENABLE, 1'b0);
    wait_neg(k + 2);
    check("loadi_wb_ready",     INSTR_READY, 1'b0);
    wait_neg(k + 3);
    check("loadi_ready_back",   INSTR_READY, 1'b1);
    check("loadi_busy_back",    BUSY,        1'b0);
    check("loadi_wr_held",      WRITEREG,    3'd3);

    // ADD r1,r2,r4 with REGOUT2=0x05
    REGOUT2 = 8'h05;
    send(32'h0201_0204, k);
    expect_wr(k, 2, 3'd1, 3'd2, 3'd4, 3'b001, 8'h05);
    wait_neg(k + 2);
    check("add_exec2_we", WRITEENABLE, 1'b0);
    wait_neg(k + 4);
    check("add_ready_back", INSTR_READY, 1'b1);

    // SUB r0,r1,r2 with REGOUT2=0x01, then sweep REGOUT2 with the select held
    REGOUT2 = 8'h01;
    send(32'h0300_0102, k);
    expect_wr(k, 2, 3'd0, 3'd1, 3'd2, 3'b001, 8'hFF);
    wait_neg(k + 4);
    REGOUT2 = 8'h80;
    #2 check("sub_neg_80", ALU_DATA2, 8'h80);
    REGOUT2 = 8'h00;
    #2 check("sub_neg_00", ALU_DATA2, 8'h00);
    REGOUT2 = 8'h03;
    #2 check("sub_neg_03", ALU_DATA2, 8'hFD);

    // MOV r5,r6 with REGOUT2=0x3C
    REGOUT2 = 8'h3C;
    send(32'h0105_0006, k);
    expect_wr(k, 1, 3'd5, 3'd0, 3'd6, 3'b000, 8'h3C);
    wait_neg(k + 3);

    // Illegal opcode 0x07
    send(32'h0703_0201, k);
    wait_neg(k);
    check("ill_decode_busy", BUSY,    1'b1);
    check("ill_decode_flag", ILLEGAL, 1'b0);
    wait_neg(k + 1);
    check("ill_flag",   ILLEGAL,     1'b1);
    check("ill_idle",   BUSY,        1'b0);
    check("ill_ready",  INSTR_READY, 1'b1);
    check("ill_aluop",  ALUOP,       3'b000);
    check("ill_addrs",  {READREG1, READREG2, WRITEREG}, 9'h000);
    check("ill_data2",  ALU_DATA2,   8'h00);
    wait_neg(k + 3);
    check("ill_sticky", ILLEGAL,     1'b1);

    // AND r6,r7,r3 clears ILLEGAL on acceptance
    REGOUT2 = 8'h0F;
    send(32'h0406_0703, k);
    expect_wr(k, 1, 3'd6, 3'd7, 3'd3, 3'b010, 8'h0F);
    wait_neg(k);
    check("and_clears_ill", ILLEGAL, 1'b0);
    wait_neg(k + 3);

    // OR aborted by reset in EXEC; VALID held high through reset
    REGOUT2 = 8'hA5;
    send(32'h0502_0304, k);
    wait_neg(k + 1);
    check("or_exec_busy", BUSY, 1'b1);
    RESET       = 1'b1;
    INSTR_VALID = 1'b1;
    INSTRUCTION = 32'h0007_0055;
    wait_neg(k + 2);
    check("abort_ready", INSTR_READY, 1'b1);
    check("abort_busy",  BUSY,        1'b0);
    check("abort_we",    WRITEENABLE, 1'b0);
    check("abort_aluop", ALUOP,       3'b000);
    check("abort_data2", ALU_DATA2,   8'h00);
    wait_neg(k + 3);
    check("rst_valid_not_taken", BUSY, 1'b0);
    RESET = 1'b0;
    wait_neg(k + 4);
    check("post_rst_accept", BUSY, 1'b1);
    INSTR_VALID = 1'b0;
    INSTRUCTION = 32'hDEAD_BEEF;
    expect_wr(k + 4, 1, 3'd7, 3'd0, 3'd5, 3'b000, 8'h55);
    wait_neg(k + 8);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
